mem32_initiator: RTL
====================

Name: mem32_initiator

Overview:
- Initiator side of the 32-bit single-ported memory interface: valid/write/wmask/wdata/word addr out, rdata back one cycle after the access.
- Turns CPU-style byte-addressed loads and stores (byte/half/word, signed/unsigned) into memory accesses.
- Generates byte masks and lane alignment.
- Splits a misaligned access that crosses a word boundary into two consecutive memory accesses and merges the results.
- Sits between a core's load/store stage and a Memory32-style RAM.

Parameters:
- WIDTH, 13, word-address width of the attached memory; byte address is WIDTH+2 bits.

Ports:
- clk  in  1  clock; everything samples on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when req_valid & req_ready.
- req_write  in  1  1=store, 0=load.
- req_size  in  2  0=byte, 1=half, 2=word; 3 is treated as word.
- req_unsigned  in  1  loads only: 1=zero-extend, 0=sign-extend.
- req_addr  in  WIDTH+2  byte address.
- req_wdata  in  32  store data, right-aligned.
- resp_valid  out  1  one-cycle pulse, exactly one per accepted request.
- resp_rdata  out  32  extended load data; 0 for stores.
- mem_valid  out  1  memory access strobe.
- mem_write  out  1  memory write enable.
- mem_wmask  out  4  byte-lane write mask.
- mem_wdata  out  32  lane-aligned write data.
- mem_addr  out  WIDTH  word address.
- mem_rdata  in  32  read data for the access issued in the previous cycle.

Behaviour:
- Interface decided: one clock, clk; reset rst, synchronous, active-high.
- States: IDLE, SPLIT2, RESP.
- Offset and split rule: off = req_addr[1:0]; A = req_addr[WIDTH+1:2]. Split iff (half & off==3) or (word & off!=0). Byte accesses never split.
- Lane shift: m = 0001/0011/1111 by size. mask64 = {4'b0,m} << off. data64 = {32'b0,wdata} << 8*off. First access uses the low halves; second access uses the high halves at word address A+1 mod 2^WIDTH. Wrap from the top word to word 0 is legal.
- Load merge: merged = ({hi_word, lo_word} >> 8*off_latched), truncated to size, then sign- or zero-extended. Non-split loads use lo_word = mem_rdata and ignore hi_word.
- req_ready = 1 in IDLE and RESP; 0 in SPLIT2 and while rst is high.
- Accept cycle T: mem_valid=1, mem_addr=A, mem_write=req_write, mem_wmask = low mask for stores and 0 for loads. These are driven combinationally from the request. Latch size, unsigned, off and write flag.
- Non-split request: next state RESP. resp_valid at T+1; load data is formed from mem_rdata in that cycle.
- Split request, T+1 (SPLIT2): issue the second access (A+1, high mask/data); capture mem_rdata into lo_reg; next state RESP. resp_valid at T+2, merged from lo_reg and mem_rdata.
- RESP: resp_valid=1. If a new request is accepted in the same cycle, its first access is issued in that cycle (back-to-back, one aligned op per cycle). Otherwise go to IDLE with mem_valid=0.
- mem_valid is never high without a pending access; mem_wmask=0 whenever mem_write=0.
- Reset: state=IDLE, resp_valid=0, req_ready=0, mem_valid=0, mem_write=0, mem_wmask=0, resp_rdata=0, lo_reg=0.
- Reset asserted mid-split: the second access is not issued, no response is produced, and the memory may hold a half-written store.
- req_valid dropped in IDLE: no access issued. Request signals are sampled only in the accept cycle.

Decomposition:
- Shared package mem32_pkg: size encodings (SIZE_B/SIZE_H/SIZE_W), state enum, and the per-size base-mask function.
- One natural combinational sub-module, mem32_lane_shift: store shift (off, size, wdata -> 64-bit mask/data) and load merge/extend (off, size, unsigned, hi, lo -> 32-bit result).
- The FSM stays in mem32_initiator.

Test Plan:
- Aligned word store 0xDEADBEEF to 0x10, then load from 0x10 -> one access (addr 4, mask 1111); load resp at T+1 = 0xDEADBEEF; back-to-back requests accepted on consecutive cycles.
- Byte store 0x80 to 0x13, then signed byte load and unsigned byte load from 0x13 -> mask 1000, wdata[31:24]=0x80; loads return 0xFFFFFF80 and 0x00000080.
- Half store 0xA55A to 0x23 -> two accesses: word 8 mask 1000 byte 0x5A, word 9 mask 0001 byte 0xA5. Signed half load from 0x23 -> 0xFFFFA55A at T+2; req_ready low at T+1.
- Word store 0x11223344 to 0x06 -> word 1 mask 1100 data[31:16]=0x3344, word 2 mask 0011 data[15:0]=0x1122. Word load from 0x06 -> 0x11223344.
- Word load at byte address (2^(WIDTH+2))-2 -> second access at word 0 (wrap); result merges the top word's upper half with word 0's lower half.
- Reset asserted in the SPLIT2 cycle of a split store -> only the first write is performed, no resp_valid, and the next request after reset completes normally.

Source files
------------

// File: rtl/mem32_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem32_pkg : shared encodings for the 32-bit memory initiator          |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package mem32_pkg;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SPLIT2 = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  // Size code 3 falls through to the full-word mask.
  function automatic logic [3:0] base_mask(input logic [1:0] size);
    case (size)
      SIZE_B:  base_mask = 4'b0001;
      SIZE_H:  base_mask = 4'b0011;
      default: base_mask = 4'b1111;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem32_lane_shift.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem32_lane_shift : store lane alignment and load merge/extension      |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module mem32_lane_shift
  import mem32_pkg::*;
(
  input  logic [1:0]  st_off,
  input  logic [1:0]  st_size,
  input  logic [31:0] st_wdata,
  output logic [7:0]  st_mask,
  output logic [63:0] st_data,
  input  logic [1:0]  ld_off,
  input  logic [1:0]  ld_size,
  input  logic        ld_unsigned,
  input  logic [31:0] ld_hi,
  input  logic [31:0] ld_lo,
  output logic [31:0] ld_data
);

  logic [31:0] merged;

  always_comb begin
    st_mask = {4'b0000, base_mask(st_size)} << st_off;
    st_data = {32'h0, st_wdata} << {st_off, 3'b000};
    merged  = 32'({ld_hi, ld_lo} >> {ld_off, 3'b000});
    case (ld_size)
      SIZE_B:  ld_data = {{24{~ld_unsigned & merged[7]}}, merged[7:0]};
      SIZE_H:  ld_data = {{16{~ld_unsigned & merged[15]}}, merged[15:0]};
      default: ld_data = merged;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem32_initiator.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem32_initiator : byte/half/word load-store to 32-bit memory adapter  |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module mem32_initiator
  import mem32_pkg::*;
#(
  parameter int WIDTH = 13
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_write,
  input  logic [1:0]       req_size,
  input  logic             req_unsigned,
  input  logic [WIDTH+1:0] req_addr,
  input  logic [31:0]      req_wdata,
  output logic             resp_valid,
  output logic [31:0]      resp_rdata,
  output logic             mem_valid,
  output logic             mem_write,
  output logic [3:0]       mem_wmask,
  output logic [31:0]      mem_wdata,
  output logic [WIDTH-1:0] mem_addr,
  input  logic [31:0]      mem_rdata
);

  state_e           state_q, state_d;
  logic [1:0]       size_q, size_d;
  logic [1:0]       off_q, off_d;
  logic             unsigned_q, unsigned_d;
  logic             write_q, write_d;
  logic             split_q, split_d;
  logic [31:0]      lo_q, lo_d;
  logic [WIDTH-1:0] addr_q, addr_d;
  logic [3:0]       hi_mask_q, hi_mask_d;
  logic [31:0]      hi_data_q, hi_data_d;

  logic [1:0]       req_off;
  logic [WIDTH-1:0] req_word;
  logic             req_split;
  logic             accept;
  logic [7:0]       st_mask;
  logic [63:0]      st_data;
  logic [31:0]      ld_data;

  assign req_off  = req_addr[1:0];
  assign req_word = req_addr[WIDTH+1:2];
  assign req_split = ((req_size == SIZE_H) && (req_off == 2'd3)) ||
                     (req_size[1] && (req_off != 2'd0));

  mem32_lane_shift u_lane_shift (
    .st_off      (req_off),
    .st_size     (req_size),
    .st_wdata    (req_wdata),
    .st_mask     (st_mask),
    .st_data     (st_data),
    .ld_off      (off_q),
    .ld_size     (size_q),
    .ld_unsigned (unsigned_q),
    .ld_hi       (mem_rdata),
    .ld_lo       (split_q ? lo_q : mem_rdata),
    .ld_data     (ld_data)
  );

  always_comb begin
    state_d    = state_q;
    size_d     = size_q;
    off_d      = off_q;
    unsigned_d = unsigned_q;
    write_d    = write_q;
    split_d    = split_q;
    lo_d       = lo_q;
    addr_d     = addr_q;
    hi_mask_d  = hi_mask_q;
    hi_data_d  = hi_data_q;
    req_ready  = 1'b0;
    accept     = 1'b0;
    resp_valid = 1'b0;
    resp_rdata = 32'h0;
    mem_valid  = 1'b0;
    mem_write  = 1'b0;
    mem_wmask  = 4'b0000;
    mem_wdata  = 32'h0;
    mem_addr   = '0;

    // While reset is high every output stays quiet, which also drops a pending second access.
    if (!rst) begin
      req_ready = (state_q != ST_SPLIT2);
      accept    = req_valid & req_ready;
      case (state_q)
        ST_SPLIT2: begin
          mem_valid = 1'b1;
          mem_write = write_q;
          mem_wmask = write_q ? hi_mask_q : 4'b0000;
          mem_wdata = hi_data_q;
          mem_addr  = addr_q;
          lo_d      = mem_rdata;
          state_d   = ST_RESP;
        end
        default: begin
          if (state_q == ST_RESP) begin
            resp_valid = 1'b1;
            resp_rdata = write_q ? 32'h0 : ld_data;
          end
          if (accept) begin
            mem_valid  = 1'b1;
            mem_write  = req_write;
            mem_wmask  = req_write ? st_mask[3:0] : 4'b0000;
            mem_wdata  = st_data[31:0];
            mem_addr   = req_word;
            size_d     = req_size;
            off_d      = req_off;
            unsigned_d = req_unsigned;
            write_d    = req_write;
            split_d    = req_split;
            addr_d     = req_word + 1'b1;
            hi_mask_d  = st_mask[7:4];
            hi_data_d  = st_data[63:32];
            state_d    = req_split ? ST_SPLIT2 : ST_RESP;
          end else begin
            state_d = ST_IDLE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      size_q     <= 2'b00;
      off_q      <= 2'b00;
      unsigned_q <= 1'b0;
      write_q    <= 1'b0;
      split_q    <= 1'b0;
      lo_q       <= 32'h0;
      addr_q     <= '0;
      hi_mask_q  <= 4'b0000;
      hi_data_q  <= 32'h0;
    end else begin
      state_q    <= state_d;
      size_q     <= size_d;
      off_q      <= off_d;
      unsigned_q <= unsigned_d;
      write_q    <= write_d;
      split_q    <= split_d;
      lo_q       <= lo_d;
      addr_q     <= addr_d;
      hi_mask_q  <= hi_mask_d;
      hi_data_q  <= hi_data_d;
    end
  end

endmodule
`default_nettype wire
